// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan driver.
package seg7_pkg;

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } phase_t;

    // Segment patterns {a,b,c,d,e,f,g}, bit 6 = a, active-high.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

    // Converts an active-high "on" request into the pin level for the given polarity.
    function automatic logic drive_level(input logic on, input bit active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load bus of the scan driver: display contents captured into the pending shadow on load.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4,
    parameter int PWM_W  = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     digit_en;
    logic                  lz_blank;
    logic [PWM_W-1:0]      brightness;

    modport master (output load, value, dp, digit_en, lz_blank, brightness);
    modport slave  (input  load, value, dp, digit_en, lz_blank, brightness);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern.
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with frame-synchronous shadow loading,
// PWM brightness, per-digit blanking, decimal points and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ         = 100000000,
    parameter int SCAN_HZ        = 250,
    parameter int DIGITS         = 4,
    parameter int PWM_W          = 4,
    parameter int BLANK_CYCLES   = 100,
    parameter bit COM_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_driver_if.slave   bus,
    output logic [6:0]          seg,
    output logic                seg_dp,
    output logic [DIGITS-1:0]   com,
    output logic                frame_start
);

    localparam int SLOT_CYC = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int PWM_P    = (1 << PWM_W) - 1;
    localparam int SW       = $clog2(SLOT_CYC);
    localparam int DW       = $clog2(DIGITS);

    localparam logic [SW-1:0]    SLOT_LAST = SW'(SLOT_CYC - 1);
    localparam logic [SW-1:0]    ON_START  = SW'(BLANK_CYCLES);
    localparam logic [DW-1:0]    DIG_LAST  = DW'(DIGITS - 1);
    localparam logic [PWM_W-1:0] PWM_LAST  = PWM_W'(PWM_P - 1);

    if (SLOT_CYC < BLANK_CYCLES + PWM_P || DIGITS < 2 || DIGITS > 8) begin : g_param_check
        $error("seg7_scan_driver: need SLOT_CYC >= BLANK_CYCLES + PWM_P and 2 <= DIGITS <= 8");
    end

    phase_t             phase, phase_nxt;
    logic [SW-1:0]      slot_cnt, slot_nxt;
    logic [DW-1:0]      dig, dig_nxt;
    logic [PWM_W-1:0]   pwm_cnt, pwm_nxt;
    logic               slot_wrap, frame_wrap;

    logic [4*DIGITS-1:0] pend_value, act_value;
    logic [DIGITS-1:0]   pend_dp, act_dp;
    logic [DIGITS-1:0]   pend_en, act_en;
    logic                pend_lz, act_lz;
    logic [PWM_W-1:0]    pend_bright, act_bright;
    logic                pend_v;

    logic [DIGITS-1:0]   supp;
    logic                lz_run;
    logic [3:0]          cur_nibble;
    logic [6:0]          dec_seg;
    logic [DIGITS-1:0]   com_drv;
    logic [6:0]          seg_drv;
    logic                dp_drv;

    // Scan state register: slot phase, prescaler, digit index and PWM counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= (ON_START == '0) ? PH_ON : PH_BLANK;
            slot_cnt <= '0;
            dig      <= '0;
            pwm_cnt  <= '0;
        end else begin
            phase    <= phase_nxt;
            slot_cnt <= slot_nxt;
            dig      <= dig_nxt;
            pwm_cnt  <= pwm_nxt;
        end
    end

    // Next scan state; phase tracks the slot_cnt it will accompany, PWM restarts at each ON phase.
    always_comb begin
        slot_wrap  = (slot_cnt == SLOT_LAST);
        frame_wrap = slot_wrap && (dig == DIG_LAST);
        slot_nxt   = slot_wrap ? '0 : slot_cnt + 1'b1;
        dig_nxt    = dig;
        if (slot_wrap) begin
            dig_nxt = (dig == DIG_LAST) ? '0 : dig + 1'b1;
        end
        phase_nxt = (slot_nxt < ON_START) ? PH_BLANK : PH_ON;
        pwm_nxt   = '0;
        if (phase == PH_ON && phase_nxt == PH_ON && !slot_wrap) begin
            pwm_nxt = (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
        end
    end

    // Pending shadow captures every load; active set swaps only on the frame boundary,
    // where a load in that very cycle bypasses the pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value  <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            pend_lz     <= 1'b0;
            pend_bright <= '0;
            pend_v      <= 1'b0;
            act_value   <= '0;
            act_dp      <= '0;
            act_en      <= '0;
            act_lz      <= 1'b0;
            act_bright  <= '0;
        end else begin
            if (bus.load) begin
                pend_value  <= bus.value;
                pend_dp     <= bus.dp;
                pend_en     <= bus.digit_en;
                pend_lz     <= bus.lz_blank;
                pend_bright <= bus.brightness;
            end
            if (frame_wrap) begin
                pend_v <= 1'b0;
                if (bus.load) begin
                    act_value  <= bus.value;
                    act_dp     <= bus.dp;
                    act_en     <= bus.digit_en;
                    act_lz     <= bus.lz_blank;
                    act_bright <= bus.brightness;
                end else if (pend_v) begin
                    act_value  <= pend_value;
                    act_dp     <= pend_dp;
                    act_en     <= pend_en;
                    act_lz     <= pend_lz;
                    act_bright <= pend_bright;
                end
            end else if (bus.load) begin
                pend_v <= 1'b1;
            end
        end
    end

    // Leading-zero mask: zeros from the top digit down are suppressed until the first non-zero.
    always_comb begin
        supp   = '0;
        lz_run = act_lz;
        for (int unsigned i = DIGITS - 1; i > 0; i--) begin
            lz_run  = lz_run && (act_value[4*i +: 4] == 4'h0);
            supp[i] = lz_run;
        end
    end

    assign cur_nibble = act_value[{dig, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Pin levels for the next cycle: dark during BLANK, PWM-gated digit select during ON.
    always_comb begin
        com_drv = '0;
        seg_drv = '0;
        dp_drv  = 1'b0;
        if (phase == PH_ON) begin
            seg_drv = dec_seg;
            dp_drv  = act_dp[dig];
            if (act_en[dig] && !supp[dig] && (pwm_cnt < act_bright)) begin
                com_drv[dig] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < DIGITS; i++) begin
            com_drv[i] = drive_level(com_drv[i], COM_ACTIVE_LOW);
        end
        for (int unsigned i = 0; i < 7; i++) begin
            seg_drv[i] = drive_level(seg_drv[i], SEG_ACTIVE_LOW);
        end
        dp_drv = drive_level(dp_drv, SEG_ACTIVE_LOW);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            com         <= {DIGITS{COM_ACTIVE_LOW}};
            seg         <= {7{SEG_ACTIVE_LOW}};
            seg_dp      <= SEG_ACTIVE_LOW;
            frame_start <= 1'b0;
        end else begin
            com         <= com_drv;
            seg         <= seg_drv;
            seg_dp      <= dp_drv;
            frame_start <= frame_wrap;
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed N-digit 7-segment scan driver with per-frame shadow loading, global PWM brightness, per-digit blanking, decimal points and leading-zero suppression. It replaces ad-hoc per-display divider/PWM wiring at top level: one instance drives one common-cathode or common-anode multi-digit display from a single system clock.

## Interface
- CLK_HZ, 100000000, system clock frequency
- SCAN_HZ, 250, full-frame refresh rate; slot length SLOT_CYC = CLK_HZ/(SCAN_HZ*DIGITS) cycles
- DIGITS, 4, number of digits (2..8)
- PWM_W, 4, brightness width; PWM period PWM_P = 2^PWM_W-1 cycles
- BLANK_CYCLES, 100, anti-ghost dead time at start of every slot
- COM_ACTIVE_LOW, 1, digit-select polarity
- SEG_ACTIVE_LOW, 0, segment/dp polarity

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe; captures value/dp/digit_en/lz_blank/brightness into pending shadow
- value  in  4*DIGITS  hex nibbles, nibble 0 = rightmost digit
- dp  in  DIGITS  decimal point per digit
- digit_en  in  DIGITS  per-digit enable (0 = blank)
- lz_blank  in  1  leading-zero suppression
- brightness  in  PWM_W  on-duty, 0 = off, PWM_P = full on
- seg  out  7  segments {a,b,c,d,e,f,g}, seg[6]=a
- seg_dp  out  1  decimal point
- com  out  DIGITS  digit selects
- frame_start  out  1  one-cycle pulse when active registers update (slot 0 begins)

## Operation
- Prescaler slot_cnt 0..SLOT_CYC-1; digit index dig 0..DIGITS-1 advances on slot_cnt wrap, dig wraps DIGITS-1 -> 0 (frame boundary).
- Slot phases: BLANK (slot_cnt < BLANK_CYCLES): all com and seg inactive. ON (rest): seg/seg_dp drive decoded active nibble dig; com[dig] active when pwm_cnt < active brightness, all other com inactive.
- pwm_cnt 0..PWM_P-1, reset to 0 at start of each ON phase, increments per cycle.
- Digit shown only if digit_en[dig]=1 and not suppressed; otherwise com[dig] stays inactive for the whole slot.
- Leading-zero suppression: with lz_blank=1, digits from DIGITS-1 downward whose nibble is 0 are suppressed until the first non-zero nibble; digit 0 is never suppressed. dp does not stop suppression.
- Hex decode a..g: 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
- Shadow: load writes pending regs, sets pend_v. At frame boundary, if pend_v, active <= pending and pend_v cleared. load in the boundary cycle itself is applied at that boundary (bypass from inputs). Multiple loads in one frame: last wins.
- Polarity applied on final output registers only.

## Timing
- Reset (async, immediate): com, seg, seg_dp inactive per polarity; frame_start 0; slot_cnt, dig, pwm_cnt 0; active and pending regs 0, pend_v 0 (display dark until first load reaches a boundary).
- Reset release: first frame boundary after SLOT_CYC*DIGITS cycles.
- All outputs registered: one clk latency from internal counters.
- load -> visible: at next frame boundary, worst case one frame (SLOT_CYC*DIGITS cycles) + 1.
- brightness change takes effect only via load/boundary; never mid-slot.
- Elaboration error unless SLOT_CYC >= BLANK_CYCLES + PWM_P and 2 <= DIGITS <= 8.

## Structure
- Package seg7_pkg: 16x7 hex segment table constant, hex-to-seg function, polarity helper.
- Sub-module seg7_hex_decode (combinational nibble -> 7-seg); remainder (prescaler, scan FSM, PWM, shadow, LZ logic) in seg7_scan_driver.

## Test plan
Bench params: CLK_HZ=64000, SCAN_HZ=250, DIGITS=4 (SLOT_CYC=64), BLANK_CYCLES=4, PWM_W=4 (PWM_P=15), COM_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0.
- rst_n low mid-ON-phase -> same cycle com=4'b1111, seg=0, seg_dp=0; after release, no com active until first boundary following a load.
- load value=16'h12AF, dp=4'b0010, digit_en=4'hF, brightness=15 -> after frame_start: slot 0 com=4'b1110 for cycles 4..63, seg=1000111; slot 1 seg=1110111, seg_dp=1; slot 3 seg=0110000.
- brightness=5 -> com[dig] low for 5 of every 15 ON cycles (20 per slot); brightness=0 -> com stays 4'b1111.
- lz_blank=1, value=16'h0070 -> digits 3,2 never selected, digit 1 shows 1110000, digit 0 shows 1111110; value=16'h0000 -> only digit 0 shown.
- load at mid-frame then second load with value=16'h5555 same frame -> display unchanged until frame_start, then shows 5555; load in boundary cycle applied at that boundary.
- digit_en=4'b0101 -> com[1], com[3] never low; BLANK phases show com=4'b1111 and seg=0 on every slot.
